// File: rtl/urp_pcie_tx_transaction_layer_if.sv
// Application-side channel buses and DLL-side TLP bus of the PCIe TX transaction layer.
// The master modport is the environment (application + data link layer); slave is the design.
interface urp_pcie_tx_transaction_layer_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic           ch0_valid_i;
    logic           ch0_ready_o;
    logic [84:0]    ch0_hdr_i;
    logic [127:0]   ch0_payload_i;
    logic [CW-1:0]  ch0_count_o;

    logic           ch1_valid_i;
    logic           ch1_ready_o;
    logic [84:0]    ch1_hdr_i;
    logic [127:0]   ch1_payload_i;
    logic [CW-1:0]  ch1_count_o;

    logic [223:0]   tlp_data_o;
    logic           tlp_data_valid_o;
    logic           tlp_data_ready_i;

    modport master (
        output ch0_valid_i, ch0_hdr_i, ch0_payload_i,
        input  ch0_ready_o, ch0_count_o,
        output ch1_valid_i, ch1_hdr_i, ch1_payload_i,
        input  ch1_ready_o, ch1_count_o,
        input  tlp_data_o, tlp_data_valid_o,
        output tlp_data_ready_i
    );

    modport slave (
        input  ch0_valid_i, ch0_hdr_i, ch0_payload_i,
        output ch0_ready_o, ch0_count_o,
        input  ch1_valid_i, ch1_hdr_i, ch1_payload_i,
        output ch1_ready_o, ch1_count_o,
        output tlp_data_o, tlp_data_valid_o,
        input  tlp_data_ready_i
    );
endinterface

// File: rtl/urp_pcie_tx_transaction_layer.sv
// PCIe TX transaction layer: two buffered channels (requests, completions), round-robin
// arbitration, and a single registered TLP output stage with valid/ready handshake.
module urp_pcie_tx_transaction_layer #(
    parameter int unsigned DEPTH = 4
) (
    input logic                             clk,
    input logic                             rst_n,
    urp_pcie_tx_transaction_layer_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned HW = 85;
    localparam int unsigned PW = 128;
    localparam int unsigned EW = HW + PW;
    localparam int unsigned TW = 224;

    logic [EW-1:0] r_mem  [2][DEPTH];
    logic [AW-1:0] r_wptr [2];
    logic [AW-1:0] r_rptr [2];
    logic [CW-1:0] r_cnt  [2];
    logic          r_rr;
    logic          r_valid;
    logic [TW-1:0] r_tlp;

    logic [1:0]    w_valid;
    logic [1:0]    w_ready;
    logic [1:0]    w_push;
    logic [1:0]    w_ne;
    logic [1:0]    w_pop;
    logic [EW-1:0] w_in [2];
    logic          w_load;
    logic          w_gnt;
    logic [EW-1:0] w_head;
    logic [TW-1:0] w_pkt;

    // 3DW header + payload; payload is zeroed for no-data formats (fmt[1] = 0)
    function automatic logic [TW-1:0] pack_tlp(input logic [EW-1:0] e);
        logic [HW-1:0] h;
        logic [PW-1:0] p;
        h = e[EW-1:PW];
        p = e[PW-1:0];
        return {h[84:82], h[81:77], 1'b0, h[76:74], 10'b0, h[73:64],
                h[63:48], h[47:32], h[31:0], (h[83] ? p : {PW{1'b0}})};
    endfunction

    assign w_valid = {bus.ch1_valid_i, bus.ch0_valid_i};
    assign w_in[0] = {bus.ch0_hdr_i, bus.ch0_payload_i};
    assign w_in[1] = {bus.ch1_hdr_i, bus.ch1_payload_i};

    always_comb begin
        w_ready = '0;
        w_ne    = '0;
        for (int c = 0; c < 2; c++) begin
            w_ready[c] = (r_cnt[c] != CW'(DEPTH));
            w_ne[c]    = (r_cnt[c] != '0);
        end
    end

    assign w_push = w_valid & w_ready;
    assign w_load = !r_valid || bus.tlp_data_ready_i;
    // w_gnt = 1 selects ch1: ch1 alone, or both pending and the pointer favours ch1
    assign w_gnt  = w_ne[1] && (!w_ne[0] || r_rr);
    assign w_pop  = w_load ? {w_ne[1] & w_gnt, w_ne[0] & ~w_gnt} : 2'b00;
    assign w_head = r_mem[w_gnt][r_rptr[w_gnt]];
    assign w_pkt  = pack_tlp(w_head);

    // FIFO storage carries no reset; validity is tracked by pointers and counts
    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (w_push[c]) begin
                r_mem[c][r_wptr[c]] <= w_in[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                r_wptr[c] <= '0;
                r_rptr[c] <= '0;
                r_cnt[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (w_push[c]) r_wptr[c] <= r_wptr[c] + AW'(1);
                if (w_pop[c])  r_rptr[c] <= r_rptr[c] + AW'(1);
                r_cnt[c] <= r_cnt[c] + CW'(w_push[c]) - CW'(w_pop[c]);
            end
        end
    end

    // Output register loads when empty or being drained; pointer moves only on a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_tlp   <= '0;
            r_rr    <= 1'b0;
        end else if (w_load) begin
            r_valid <= |w_ne;
            if (|w_ne) begin
                r_tlp <= w_pkt;
                r_rr  <= ~w_gnt;
            end
        end
    end

    assign bus.ch0_ready_o      = w_ready[0];
    assign bus.ch1_ready_o      = w_ready[1];
    assign bus.ch0_count_o      = r_cnt[0];
    assign bus.ch1_count_o      = r_cnt[1];
    assign bus.tlp_data_o       = r_tlp;
    assign bus.tlp_data_valid_o = r_valid;
endmodule

// File: tb/tb_urp_pcie_tx_transaction_layer.sv
// Scoreboard bench for the PCIe TX transaction layer: queue-based reference model,
// negedge monitor, directed scenarios followed by randomized traffic and backpressure.
module tb_urp_pcie_tx_transaction_layer;
    localparam int unsigned DEPTH = 4;

    typedef logic [212:0] entry_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    urp_pcie_tx_transaction_layer_if #(.DEPTH(DEPTH)) bus ();
    urp_pcie_tx_transaction_layer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    entry_t       mq0[$];
    entry_t       mq1[$];
    logic [223:0] exp_q[$];
    bit           m_valid;
    int           m_last;
    int           m_g;
    bit           m_p0, m_p1;
    entry_t       m_e0, m_e1;

    bit           a0, a1;
    bit           stall_prev = 1'b0;
    logic [223:0] held;
    logic [223:0] exp_tlp;
    bit           ok;

    task automatic check(input string name, input logic [223:0] act, input logic [223:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // TLP layout from the header field rules
    function automatic logic [223:0] tlp_of(input entry_t e);
        logic [2:0]   fmt;
        logic [4:0]   typ;
        logic [2:0]   tc;
        logic [9:0]   len;
        logic [31:0]  dw0, dw1, dw2;
        logic [127:0] pl;
        fmt = e[212:210];
        typ = e[209:205];
        tc  = e[204:202];
        len = e[201:192];
        dw0 = (32'(fmt) << 29) | (32'(typ) << 24) | (32'(tc) << 20) | 32'(len);
        dw1 = e[191:160];
        dw2 = e[159:128];
        pl  = fmt[1] ? e[127:0] : 128'd0;
        return {dw0, dw1, dw2, pl};
    endfunction

    // Reference model: two bounded queues, one output slot, alternate on contention
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq0.delete();
            mq1.delete();
            exp_q.delete();
            m_valid = 1'b0;
            m_last  = 1;
        end else begin
            m_p0 = bus.ch0_valid_i && (mq0.size() < DEPTH);
            m_p1 = bus.ch1_valid_i && (mq1.size() < DEPTH);
            m_e0 = {bus.ch0_hdr_i, bus.ch0_payload_i};
            m_e1 = {bus.ch1_hdr_i, bus.ch1_payload_i};
            if (!m_valid || bus.tlp_data_ready_i) begin
                if (mq0.size() == 0 && mq1.size() == 0) begin
                    m_valid = 1'b0;
                end else begin
                    if (mq0.size() == 0)      m_g = 1;
                    else if (mq1.size() == 0) m_g = 0;
                    else                      m_g = (m_last == 0) ? 1 : 0;
                    m_last = m_g;
                    if (m_g == 1) exp_q.push_back(tlp_of(mq1.pop_front()));
                    else          exp_q.push_back(tlp_of(mq0.pop_front()));
                    m_valid = 1'b1;
                end
            end
            if (m_p0) mq0.push_back(m_e0);
            if (m_p1) mq1.push_back(m_e1);
        end
    end

    // Monitor: status against the model, payload against the scoreboard on each handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            check("tlp_valid", 224'(bus.tlp_data_valid_o), 224'(m_valid));
            check("ch0_count", 224'(bus.ch0_count_o), 224'(mq0.size()));
            check("ch1_count", 224'(bus.ch1_count_o), 224'(mq1.size()));
            check("ch0_ready", 224'(bus.ch0_ready_o), 224'(mq0.size() < DEPTH));
            check("ch1_ready", 224'(bus.ch1_ready_o), 224'(mq1.size() < DEPTH));
            if (stall_prev && bus.tlp_data_valid_o)
                check("hold_stable", bus.tlp_data_o, held);
            if (bus.tlp_data_valid_o && bus.tlp_data_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_tlp", bus.tlp_data_o, 224'd0);
                end else begin
                    exp_tlp = exp_q.pop_front();
                    check("tlp_data", bus.tlp_data_o, exp_tlp);
                end
            end
            stall_prev = bus.tlp_data_valid_o && !bus.tlp_data_ready_i;
            held       = bus.tlp_data_o;
        end
    end

    // One clock: note accepted offers, then retire them just after the edge
    task automatic tick();
        @(negedge clk);
        a0 = bus.ch0_valid_i && bus.ch0_ready_o;
        a1 = bus.ch1_valid_i && bus.ch1_ready_o;
        @(posedge clk);
        #1;
        if (a0) bus.ch0_valid_i = 1'b0;
        if (a1) bus.ch1_valid_i = 1'b0;
    endtask

    task automatic offer(input int c, input entry_t e);
        if (c == 0) begin
            bus.ch0_valid_i = 1'b1;
            {bus.ch0_hdr_i, bus.ch0_payload_i} = e;
        end else begin
            bus.ch1_valid_i = 1'b1;
            {bus.ch1_hdr_i, bus.ch1_payload_i} = e;
        end
    endtask

    task automatic wait_taken(input int maxc, output bit done);
        for (int i = 0; i < maxc && (bus.ch0_valid_i || bus.ch1_valid_i); i++) tick();
        done = !(bus.ch0_valid_i || bus.ch1_valid_i);
    endtask

    function automatic entry_t rand_entry();
        entry_t e;
        e = '0;
        for (int i = 0; i < 7; i++) e = {e[180:0], 32'($urandom)};
        return e;
    endfunction

    function automatic entry_t mk(input logic [2:0] fmt, input logic [31:0] addr,
                                  input logic [127:0] pl);
        return {fmt, 5'b00000, 3'd1, 10'd4, 16'h0100, 16'h0000, addr, pl};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.ch0_valid_i = 1'b0; bus.ch0_hdr_i = '0; bus.ch0_payload_i = '0;
        bus.ch1_valid_i = 1'b0; bus.ch1_hdr_i = '0; bus.ch1_payload_i = '0;
        bus.tlp_data_ready_i = 1'b0;

        // Reset values
        #12;
        check("rst_valid", 224'(bus.tlp_data_valid_o), 224'd0);
        check("rst_data", bus.tlp_data_o, 224'd0);
        check("rst_cnt0", 224'(bus.ch0_count_o), 224'd0);
        check("rst_rdy1", 224'(bus.ch1_ready_o), 224'd1);
        @(posedge clk); #1; rst_n = 1'b1;

        // Single write with data: two-cycle latency and exact header dwords
        offer(0, mk(3'b010, 32'h1000_0040, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE));
        tick();
        check("lat_e0_valid", 224'(bus.tlp_data_valid_o), 224'd0);
        tick();
        check("lat_e1_valid", 224'(bus.tlp_data_valid_o), 224'd1);
        check("single_dw0", 224'(bus.tlp_data_o[223:192]), 224'h4010_0004);
        check("single_dw1", 224'(bus.tlp_data_o[191:160]), 224'h0100_0000);
        check("single_dw2", 224'(bus.tlp_data_o[159:128]), 224'h1000_0040);
        check("single_pl", 224'(bus.tlp_data_o[127:0]), 224'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE);
        bus.tlp_data_ready_i = 1'b1;
        repeat (3) tick();

        // No-data TLP on ch1: payload field forced to zero
        bus.tlp_data_ready_i = 1'b0;
        offer(1, mk(3'b000, 32'h2000_0000, {128{1'b1}}));
        tick(); tick();
        check("nodata_pl", 224'(bus.tlp_data_o[127:0]), 224'd0);
        bus.tlp_data_ready_i = 1'b1;
        repeat (3) tick();

        // Round robin: preload both channels, then drain
        bus.tlp_data_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            offer(0, mk(3'b011, 32'hA000_0000 + 32'(k), 128'(k)));
            offer(1, mk(3'b010, 32'hB000_0000 + 32'(k), 128'(k + 16)));
            wait_taken(4, ok);
            check("rr_accept", 224'(ok), 224'd1);
        end
        bus.tlp_data_ready_i = 1'b1;
        repeat (8) tick();
        check("rr_cnt0", 224'(bus.ch0_count_o), 224'd0);
        check("rr_cnt1", 224'(bus.ch1_count_o), 224'd0);

        // Backpressure: DEPTH+2 offers into ch0; the last one must be refused
        bus.tlp_data_ready_i = 1'b0;
        for (int k = 0; k < DEPTH + 2; k++) begin
            offer(0, rand_entry());
            wait_taken(4, ok);
            check("full_accept", 224'(ok), 224'(k < DEPTH + 1));
        end
        bus.ch0_valid_i = 1'b0;
        check("full_cnt", 224'(bus.ch0_count_o), 224'(DEPTH));
        check("full_rdy", 224'(bus.ch0_ready_o), 224'd0);
        bus.tlp_data_ready_i = 1'b1;
        repeat (8) tick();

        // Streaming: push every cycle with ready high, occupancy steady at one
        for (int k = 0; k < 20; k++) begin
            offer(0, rand_entry());
            tick();
        end
        check("stream_cnt", 224'(bus.ch0_count_o), 224'd1);
        bus.ch0_valid_i = 1'b0;
        repeat (4) tick();

        // Randomized traffic and backpressure
        for (int k = 0; k < 1500; k++) begin
            if (!bus.ch0_valid_i && ($urandom_range(1, 0) == 1)) offer(0, rand_entry());
            if (!bus.ch1_valid_i && ($urandom_range(1, 0) == 1)) offer(1, rand_entry());
            bus.tlp_data_ready_i = ($urandom_range(3, 0) != 0);
            tick();
        end
        bus.ch0_valid_i = 1'b0;
        bus.ch1_valid_i = 1'b0;
        bus.tlp_data_ready_i = 1'b1;
        repeat (12) tick();

        // Asynchronous reset while a TLP is presented
        bus.tlp_data_ready_i = 1'b0;
        offer(0, rand_entry());
        wait_taken(4, ok);
        offer(0, rand_entry());
        wait_taken(4, ok);
        check("pre_rst_valid", 224'(bus.tlp_data_valid_o), 224'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.ch0_valid_i = 1'b0;
        bus.ch1_valid_i = 1'b0;
        #1;
        check("async_valid", 224'(bus.tlp_data_valid_o), 224'd0);
        check("async_cnt0", 224'(bus.ch0_count_o), 224'd0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        check("post_rdy0", 224'(bus.ch0_ready_o), 224'd1);
        bus.tlp_data_ready_i = 1'b1;
        offer(0, mk(3'b010, 32'hC000_0000, 128'h1));
        offer(1, mk(3'b010, 32'hD000_0000, 128'h2));
        tick(); tick();
        check("post_first_ch0", 224'(bus.tlp_data_o[159:128]), 224'hC000_0000);
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
